// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA 640x480@60 timing generator and registered RGB/sync output stage
module vga_timing #(
    parameter int CLK_DIV = 2,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int V_BP    = 33,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] next_color,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       req,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb
);

    localparam int H_TOT = H_BP + H_ACT + H_FP + H_SYNC;
    localparam int V_TOT = V_BP + V_ACT + V_FP + V_SYNC;
    localparam int DW    = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    // Line layout: back porch first, so col 0 is the start of the back porch
    // and pixel_gen can subtract H_BP to get its logical x coordinate.
    localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
    localparam logic [9:0] H_ACT_START  = 10'(H_BP);
    localparam logic [9:0] H_ACT_END    = 10'(H_BP + H_ACT);
    localparam logic [9:0] H_SYNC_START = 10'(H_BP + H_ACT + H_FP);

    localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
    localparam logic [9:0] V_ACT_START  = 10'(V_BP);
    localparam logic [9:0] V_ACT_END    = 10'(V_BP + V_ACT);
    localparam logic [9:0] V_SYNC_START = 10'(V_BP + V_ACT + V_FP);

    logic [DW-1:0] div;
    logic          pix_en;
    logic          h_vis;
    logic          v_vis;
    logic          visible;
    logic          h_sync_band;
    logic          v_sync_band;
    logic          vis_d;
    logic          hs_d;
    logic          vs_d;

    // Pixel enable fires on the last system clock of each pixel period.
    assign pix_en = (div == DIV_LAST);

    // Region decode from the registered counters only, so req is glitch-free
    // relative to the clock edge that pixel_gen samples it on.
    assign h_vis       = (col >= H_ACT_START) && (col < H_ACT_END);
    assign v_vis       = (row >= V_ACT_START) && (row < V_ACT_END);
    assign visible     = h_vis && v_vis;
    assign h_sync_band = (col >= H_SYNC_START);
    assign v_sync_band = (row >= V_SYNC_START);

    // One request per active pixel, on the edge where that pixel is consumed.
    assign req = pix_en && visible;

    // System-clock divider producing the pixel cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Horizontal and vertical counters, stepping once per pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_en) begin
            if (col == H_LAST) begin
                col <= '0;
                if (row == V_LAST) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // First pipeline stage: capture region flags for the pixel being requested,
    // so they line up with next_color arriving one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis_d <= 1'b0;
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
        end else if (pix_en) begin
            vis_d <= visible;
            hs_d  <= !h_sync_band;
            vs_d  <= !v_sync_band;
        end
    end

    // Output stage: colour and sync leave together; colour is gated by the
    // delayed visible flag so nothing from pixel_gen leaks into blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            rgb   <= vis_d ? next_color : 8'h00;
            hsync <= hs_d;
            vsync <= vs_d;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed self-checking bench for vga_timing
module tb_vga_timing;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_s;
    logic [7:0] nc;
    logic [7:0] nc_s;
    logic [9:0] col, row, col_s, row_s;
    logic       req, hsync, vsync, req_s, hsync_s, vsync_s;
    logic [7:0] rgb, rgb_s;

    int checks = 0;
    int errors = 0;
    int pos    = 0;

    int hs_low, vs_low, ff_cnt, bad_cnt, req_cnt, hs_fall;
    logic prev_hs;
    logic found;

    always #5 clk = ~clk;

    // Default 640x480 timing.
    vga_timing dut (
        .clk(clk), .rst(rst), .next_color(nc),
        .col(col), .row(row), .req(req),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    // Shrunk timing (17 x 11 pixels, 3 clks per pixel) so whole frames fit.
    vga_timing #(
        .CLK_DIV(3), .H_BP(4), .H_ACT(8), .H_FP(2), .H_SYNC(3),
        .V_BP(3), .V_ACT(4), .V_FP(2), .V_SYNC(2)
    ) dut_s (
        .clk(clk), .rst(rst_s), .next_color(nc_s),
        .col(col_s), .row(row_s), .req(req_s),
        .hsync(hsync_s), .vsync(vsync_s), .rgb(rgb_s)
    );

    // pixel_gen stand-in: colour = col ^ row, latched on req.
    always @(posedge clk) begin
        if (rst)      nc <= 8'h00;
        else if (req) nc <= col[7:0] ^ row[7:0];
    end

    assign nc_s = 8'hFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the negedge following the k-th posedge since reset release.
    task automatic run_to(input int k);
        while (pos < k) begin
            @(posedge clk);
            pos++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col",   col,   0);
        check("rst_row",   row,   0);
        check("rst_req",   req,   0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_rgb",   rgb,   0);
        rst = 1'b0;
        pos = 0;

        // Default timing: first line and first active pixel.
        run_to(1);     check("d_col_k1", col, 0);  check("d_req_k1", req, 0);
        run_to(2);     check("d_col_k2", col, 1);
        run_to(1409);  check("d_col_704", col, 704);
        run_to(1411);  check("d_hs_pre", hsync, 1);
        run_to(1412);  check("d_hs_fall", hsync, 0);
        run_to(1600);  check("d_row1", row, 1);     check("d_col_wrap", col, 0);
        run_to(1603);  check("d_hs_last", hsync, 0);
        run_to(1604);  check("d_hs_rise", hsync, 1);
        run_to(52896); check("d_req_pre", req, 0);
        run_to(52897); check("d_req_first", req, 1);
        check("d_req_col", col, 48);
        check("d_req_row", row, 33);
        run_to(52898); check("d_req_one", req, 0);
        run_to(52899); check("d_rgb_c47", rgb, 8'h00);
        run_to(52900); check("d_rgb_48_33", rgb, 8'h11);
        run_to(52902); check("d_rgb_49_33", rgb, 8'h10);

        // Shrunk timing: two full frames with next_color stuck at FF.
        rst_s   = 1'b0;
        pos     = 0;
        hs_low  = 0; vs_low = 0; ff_cnt = 0; bad_cnt = 0; req_cnt = 0; hs_fall = 0;
        prev_hs = 1'b1;
        for (int k = 1; k <= 1127; k++) begin
            run_to(k);
            if (k >= 6) begin
                if (!hsync_s) hs_low++;
                if (!vsync_s) vs_low++;
                if (rgb_s == 8'hFF) ff_cnt++;
                else if (rgb_s != 8'h00) bad_cnt++;
                if (req_s) req_cnt++;
                if (prev_hs && !hsync_s) hs_fall++;
                prev_hs = hsync_s;
            end
            case (k)
                120:  check("s_rgb_bp_row",  rgb_s, 8'h00);
                170:  check("s_rgb_bp_col",  rgb_s, 8'h00);
                171:  check("s_rgb_first",   rgb_s, 8'hFF);
                192:  check("s_rgb_last",    rgb_s, 8'hFF);
                195:  check("s_rgb_fp_col",  rgb_s, 8'h00);
                324:  check("s_rgb_row6",    rgb_s, 8'hFF);
                375:  check("s_rgb_fp_row",  rgb_s, 8'h00);
                464:  check("s_vs_pre",      vsync_s, 1);
                465:  check("s_vs_fall",     vsync_s, 0);
                560:  begin check("s_col_end", col_s, 16); check("s_row_end", row_s, 10); end
                561:  begin check("s_col_f1", col_s, 0); check("s_row_f1", row_s, 0); end
                1122: begin check("s_col_f2", col_s, 0); check("s_row_f2", row_s, 0); end
                default: ;
            endcase
        end
        check("s_hs_low_clks", hs_low,  198);
        check("s_vs_low_clks", vs_low,  204);
        check("s_hs_pulses",   hs_fall, 22);
        check("s_ff_clks",     ff_cnt,  192);
        check("s_blank_leak",  bad_cnt, 0);
        check("s_req_count",   req_cnt, 64);

        // Mid-frame reset while both syncs are low.
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            run_to(pos + 1);
            if (col_s == 10'd16 && row_s == 10'd9) found = 1'b1;
        end
        check("s_wait_sync_pt", found, 1);
        check("s_hs_low_pre",   hsync_s, 0);
        check("s_vs_low_pre",   vsync_s, 0);
        rst_s = 1'b1;
        #1;
        check("s_mrst_hsync", hsync_s, 1);
        check("s_mrst_vsync", vsync_s, 1);
        check("s_mrst_req",   req_s,   0);
        check("s_mrst_rgb",   rgb_s,   0);
        check("s_mrst_col",   col_s,   0);
        check("s_mrst_row",   row_s,   0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        pos   = 0;
        run_to(166); check("s_rel_req_pre", req_s, 0);
        run_to(167); check("s_rel_req",     req_s, 1);
        check("s_rel_col", col_s, 4);
        check("s_rel_row", row_s, 3);

        // Mid-frame reset while colour is on the pins.
        run_to(282); check("s_vis_rgb", rgb_s, 8'hFF);
        rst_s = 1'b1;
        #1;
        check("s_mrst2_rgb", rgb_s, 0);
        check("s_mrst2_req", req_s, 0);
        check("s_mrst2_col", col_s, 0);
        @(negedge clk);
        rst_s = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
